arb8_ctrl: RTL and testbench

Sequential arbiter sharing one downstream resource between 8 requesters, using the same 8-to-3 priority rule as the team's priority encoder: the highest set index wins. It registers the winner, holds the grant until the owner signals done, drops its request or exceeds a hold limit, then inserts one turnaround cycle before re-arbitrating. It sits between requester blocks and the shared resource (display/bus/encoder datapath) and drives the select code and the one-hot grant.

---
 rtl/arb8_pkg.sv | 14 +
 rtl/arb8_prio_pick8.sv | 29 ++
 rtl/arb8_ctrl.sv | 113 +++++++++++
 tb/tb_arb8_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/arb8_pkg.sv
// Shared definitions for the 8-requester arbiter: FSM state encoding and
// requester/index widths used by the controller and the priority picker.
package arb8_pkg;

   localparam int NREQ = 8;
   localparam int IDW  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb8_prio_pick8.sv
// Combinational 8-way picker: searches the request vector downward from
// 'start', wrapping from 0 back to 7, and reports the first set index.
// With start tied to 7 this is the plain highest-index-wins encoder.
module prio_pick8
   import arb8_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  start,
   output logic [IDW-1:0]  id,
   output logic            hit
);

   logic [IDW-1:0] idx;

   // Walk all eight positions from start downward and latch onto the first hit
   always_comb begin
      id  = '0;
      hit = 1'b0;
      idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = start - IDW'(k);
         if (!hit && req[idx]) begin
            hit = 1'b1;
            id  = idx;
         end
      end
   end

endmodule

// File: rtl/arb8_ctrl.sv
// Grant controller sharing one resource among 8 requesters. A grant is held
// until done, request drop or the hold limit, followed by one turnaround
// cycle. Optional macro ARB_ROUND_ROBIN_EN switches the picker start point
// from fixed 7 to one below the last served index (fairness mode).
module arb8_ctrl
   import arb8_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            gnt_valid,
   output logic            timeout
);

   arb_state_t     state, state_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic [IDW-1:0] pick_start;
   logic [IDW-1:0] pick_id;
   logic           pick_hit;
   logic           at_limit;
   logic           owner_req;
   logic           release_now;
   logic           limit_only;

`ifdef ARB_ROUND_ROBIN_EN
   logic [IDW-1:0] last_id;

   // Remember the most recent winner so it becomes lowest priority next round
   always_ff @(posedge clk) begin
      if (rst)
         last_id <= '0;
      else if (state == IDLE && en && pick_hit)
         last_id <= pick_id;
   end

   assign pick_start = last_id - IDW'(1);
`else
   assign pick_start = IDW'(NREQ - 1);
`endif

   prio_pick8 u_pick (
      .req   (req),
      .start (pick_start),
      .id    (pick_id),
      .hit   (pick_hit)
   );

   assign at_limit    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
   assign owner_req   = req[gnt_id];
   assign release_now = done || !owner_req || at_limit;
   assign limit_only  = at_limit && !done && owner_req;

   // Next-state decision: arbitrate in IDLE, watch release causes in GRANT
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en && pick_hit) state_nxt = GRANT;
         GRANT:   if (release_now)    state_nxt = TURN;
         TURN:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, hold counter and registered outputs all advance together
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state   <= state_nxt;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               hold_cnt <= '0;
               if (en && pick_hit) begin
                  gnt       <= NREQ'(1) << pick_id;
                  gnt_id    <= pick_id;
                  gnt_valid <= 1'b1;
               end
            end
            GRANT: begin
               if (release_now) begin
                  gnt       <= '0;
                  gnt_id    <= '0;
                  gnt_valid <= 1'b0;
                  hold_cnt  <= '0;
                  timeout   <= limit_only;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: begin
               gnt       <= '0;
               gnt_id    <= '0;
               gnt_valid <= 1'b0;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arb8_ctrl.sv
// Directed bench for arb8_ctrl with MAX_HOLD=4. Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point, i.e. they
// reflect the edge just taken. Honors ARB_ROUND_ROBIN_EN for the last test.
module tb_arb8_ctrl;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   arb8_ctrl #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r_en, input logic [7:0] r_req, input logic r_done);
      en   = r_en;
      req  = r_req;
      done = r_done;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                              input logic e_valid, input logic e_to);
      checks++;
      assert (gnt === e_gnt) else begin
         errors++;
         $error("[TB] FAIL %s gnt observed %h expected %h", tag, gnt, e_gnt);
      end
      checks++;
      assert (gnt_id === e_id) else begin
         errors++;
         $error("[TB] FAIL %s gnt_id observed %0d expected %0d", tag, gnt_id, e_id);
      end
      checks++;
      assert (gnt_valid === e_valid) else begin
         errors++;
         $error("[TB] FAIL %s gnt_valid observed %b expected %b", tag, gnt_valid, e_valid);
      end
      checks++;
      assert (timeout === e_to) else begin
         errors++;
         $error("[TB] FAIL %s timeout observed %b expected %b", tag, timeout, e_to);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   logic [2:0] rr_exp [9];

   // Linear sequence of directed steps
   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);

      // Reset with every request asserted
      applyStimulus(1'b1, 8'hFF, 1'b0);
      tick();
      tick();
      checkOutput("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      checkOutput("first_grant_7", 8'h80, 3'd7, 1'b1, 1'b0);

      // Priority and done
      doReset();
      applyStimulus(1'b1, 8'b0010_0110, 1'b0);
      tick();
      checkOutput("prio_5", 8'h20, 3'd5, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("prio_5_hold", 8'h20, 3'd5, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'b0010_0110, 1'b1);
      tick();
      checkOutput("done_turn", 8'h00, 3'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'b0000_0110, 1'b0);
      tick();
      checkOutput("idle_after_turn", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      checkOutput("prio_2", 8'h04, 3'd2, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'b0000_0010, 1'b1);
      tick();
      checkOutput("done2_turn", 8'h00, 3'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'b0000_0010, 1'b0);
      tick();
      tick();
      checkOutput("prio_1", 8'h02, 3'd1, 1'b1, 1'b0);

      // Hold limit: four grant cycles then a timeout pulse
      doReset();
      applyStimulus(1'b1, 8'h08, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("hold_cycle_%0d", i), 8'h08, 3'd3, 1'b1, 1'b0);
         tick();
      end
      checkOutput("timeout_turn", 8'h00, 3'd0, 1'b0, 1'b1);
      tick();
      checkOutput("timeout_idle", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      checkOutput("regrant_3", 8'h08, 3'd3, 1'b1, 1'b0);

      // No preemption, then drop releases the grant
      doReset();
      applyStimulus(1'b1, 8'h04, 1'b0);
      tick();
      checkOutput("owner_2", 8'h04, 3'd2, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h44, 1'b0);
      tick();
      checkOutput("no_preempt_a", 8'h04, 3'd2, 1'b1, 1'b0);
      tick();
      checkOutput("no_preempt_b", 8'h04, 3'd2, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h40, 1'b0);
      tick();
      checkOutput("drop_turn", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("grant_6", 8'h40, 3'd6, 1'b1, 1'b0);
      tick();
      tick();
      tick();
      checkOutput("limit_cycle", 8'h40, 3'd6, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h40, 1'b1);
      tick();
      checkOutput("done_at_limit", 8'h00, 3'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h40, 1'b0);

      // Enable low during grant
      doReset();
      applyStimulus(1'b1, 8'h02, 1'b0);
      tick();
      checkOutput("en_grant_1", 8'h02, 3'd1, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h02, 1'b0);
      tick();
      checkOutput("en_low_keeps", 8'h02, 3'd1, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h02, 1'b1);
      tick();
      checkOutput("en_low_done", 8'h00, 3'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h02, 1'b0);
      tick();
      tick();
      tick();
      checkOutput("en_low_blocked", 8'h00, 3'd0, 1'b0, 1'b0);

      // Reset in the middle of a grant
      applyStimulus(1'b1, 8'h02, 1'b0);
      tick();
      checkOutput("pre_reset_grant", 8'h02, 3'd1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      checkOutput("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Continuous full request with done each grant
`ifdef ARB_ROUND_ROBIN_EN
      rr_exp = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
      rr_exp = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
      doReset();
      applyStimulus(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 9; i++) begin
         logic [7:0] one_hot;
         tick();
         one_hot = 8'h01 << rr_exp[i];
         checkOutput($sformatf("seq_%0d", i), one_hot, rr_exp[i], 1'b1, 1'b0);
         applyStimulus(1'b1, 8'hFF, 1'b1);
         tick();
         applyStimulus(1'b1, 8'hFF, 1'b0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
